// File: rtl/count_frame_pkg.sv
// rtl/count_frame_pkg.sv - shared state encoding and frame constants for count_frame_tx
package count_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    C0,
    C1,
    CHK
  } state_t;

  localparam logic [7:0] HEADER_DEF = 8'hA5;

  function automatic int FRAME_BYTES(input int cnt_w);
    return 2 + cnt_w / 4;
  endfunction

endpackage

// File: rtl/count_frame_tx_byte_sel.sv
// rtl/count_frame_tx_byte_sel.sv - combinational pick of the frame byte on the wire
module frame_byte_sel
  import count_frame_pkg::*;
#(
  parameter int         CNT_W  = 64,
  parameter logic [7:0] HEADER = HEADER_DEF,
  parameter int         IDX_W  = 3
) (
  input  state_t             i_state,
  input  logic [IDX_W-1:0]   i_idx,
  input  logic [CNT_W-1:0]   i_shadow0,
  input  logic [CNT_W-1:0]   i_shadow1,
  input  logic [7:0]         i_chk,
  output logic [7:0]         o_byte
);

  int w_hi;

  // Byte 0 is the most significant byte of the count.
  assign w_hi = CNT_W - 1 - 8 * int'(i_idx);

  always_comb begin
    o_byte = 8'h00;
    case (i_state)
      HDR:     o_byte = HEADER;
      C0:      o_byte = i_shadow0[w_hi -: 8];
      C1:      o_byte = i_shadow1[w_hi -: 8];
      CHK:     o_byte = i_chk;
      default: o_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/count_frame_tx.sv
// rtl/count_frame_tx.sv - snapshots two counts and streams them as a checksummed byte frame
module count_frame_tx
  import count_frame_pkg::*;
#(
  parameter int         CNT_W  = 64,
  parameter logic [7:0] HEADER = HEADER_DEF
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [CNT_W-1:0] Count0,
  input  logic [CNT_W-1:0] Count1,
  output logic [7:0]       Tx_Data,
  output logic             Tx_Valid,
  input  logic             Tx_Ready,
  output logic             Busy,
  output logic             Done,
  output logic             Overrun,
  output logic [15:0]      Frames_Sent
);

  localparam int NB    = CNT_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  if (CNT_W % 8 != 0 || CNT_W < 8) begin : g_bad_width
    $error("count_frame_tx: CNT_W must be a positive multiple of 8");
  end

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_shadow0;
  logic [CNT_W-1:0] r_shadow1;
  logic [7:0]       r_chk;
  logic             r_tx_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_overrun;
  logic [15:0]      r_frames_sent;
  logic             w_xfer;
  logic [7:0]       w_byte;

  assign w_xfer = r_tx_valid && Tx_Ready;

  frame_byte_sel #(
    .CNT_W  (CNT_W),
    .HEADER (HEADER),
    .IDX_W  (IDX_W)
  ) u_byte_sel (
    .i_state   (r_state),
    .i_idx     (r_idx),
    .i_shadow0 (r_shadow0),
    .i_shadow1 (r_shadow1),
    .i_chk     (r_chk),
    .o_byte    (w_byte)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_shadow0     <= '0;
      r_shadow1     <= '0;
      r_chk         <= 8'h00;
      r_tx_valid    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_overrun     <= 1'b0;
      r_frames_sent <= 16'h0000;
    end else begin
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      // Requests are never queued; any Start outside IDLE is reported and dropped.
      if (Start && r_state != IDLE) r_overrun <= 1'b1;
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_shadow0  <= Count0;
            r_shadow1  <= Count1;
            r_chk      <= HEADER;
            r_idx      <= '0;
            r_state    <= HDR;
            r_tx_valid <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        HDR: begin
          if (w_xfer) begin
            r_state <= C0;
            r_idx   <= '0;
          end
        end
        C0: begin
          if (w_xfer) begin
            r_chk <= r_chk ^ w_byte;
            if (r_idx == LAST_IDX) begin
              r_state <= C1;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        C1: begin
          if (w_xfer) begin
            r_chk <= r_chk ^ w_byte;
            if (r_idx == LAST_IDX) begin
              r_state <= CHK;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        CHK: begin
          if (w_xfer) begin
            r_state       <= IDLE;
            r_tx_valid    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_frames_sent <= r_frames_sent + 16'd1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign Tx_Data     = w_byte;
  assign Tx_Valid    = r_tx_valid;
  assign Busy        = r_busy;
  assign Done        = r_done;
  assign Overrun     = r_overrun;
  assign Frames_Sent = r_frames_sent;

endmodule

// File: tb/tb_count_frame_tx.sv
// tb/tb_count_frame_tx.sv - scoreboard bench for count_frame_tx
module tb_count_frame_tx;
  import count_frame_pkg::*;

  localparam int CW = 64;
  localparam int FB = FRAME_BYTES(CW);

  logic          Clk;
  logic          Reset_n;
  logic          Start;
  logic [CW-1:0] Count0;
  logic [CW-1:0] Count1;
  logic [7:0]    Tx_Data;
  logic          Tx_Valid;
  logic          Tx_Ready;
  logic          Busy;
  logic          Done;
  logic          Overrun;
  logic [15:0]   Frames_Sent;

  count_frame_tx #(.CNT_W(CW), .HEADER(8'hA5)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Start       (Start),
    .Count0      (Count0),
    .Count1      (Count1),
    .Tx_Data     (Tx_Data),
    .Tx_Valid    (Tx_Valid),
    .Tx_Ready    (Tx_Ready),
    .Busy        (Busy),
    .Done        (Done),
    .Overrun     (Overrun),
    .Frames_Sent (Frames_Sent)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0]  data;
    bit          last;
    logic [15:0] fs;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] model_fs = 16'h0000;
  int          rdy_mode = 0;
  bit          inc_c0 = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_frame(input logic [63:0] c0, input logic [63:0] c1, input logic [7:0] chk);
    exp_t e;
    e.last = 1'b0;
    e.fs   = 16'h0000;
    e.data = 8'hA5;
    exp_q.push_back(e);
    for (int i = 0; i < 8; i++) begin
      e.data = c0[63-8*i -: 8];
      exp_q.push_back(e);
    end
    for (int i = 0; i < 8; i++) begin
      e.data = c1[63-8*i -: 8];
      exp_q.push_back(e);
    end
    model_fs = model_fs + 16'd1;
    e.data = chk;
    e.last = 1'b1;
    e.fs   = model_fs;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    if (rdy_mode == 1) Tx_Ready = ~Tx_Ready;
    else Tx_Ready = (rdy_mode == 0);
    if (inc_c0) Count0 = Count0 + 64'd1;
  endtask

  task automatic start_frame(input logic [63:0] c0, input logic [63:0] c1, input logic [7:0] chk);
    Count0 = c0;
    Count1 = c1;
    Start  = 1'b1;
    push_frame(c0, c1, chk);
    tick();
    Start = 1'b0;
    check("start_busy", Busy, 1);
    check("start_valid", Tx_Valid, 1);
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || Busy) && cyc < 4 * FB) begin
      tick();
      cyc++;
    end
    if (cyc >= 4 * FB) begin
      n_vec++;
      n_err++;
      $display("FAIL frame_timeout: got %0d bytes pending expected 0", exp_q.size());
    end
    tick();
    tick();
  endtask

  bit          stall;
  logic [7:0]  stall_data;
  bit          pend;
  logic [15:0] pend_fs;
  exp_t        me;

  always @(negedge Clk) begin
    if (!Reset_n) begin
      stall = 1'b0;
      pend  = 1'b0;
    end else begin
      if (pend) begin
        check("done_pulse", Done, 1);
        check("frames_sent", Frames_Sent, pend_fs);
        pend = 1'b0;
      end else if (Done) begin
        check("done_spurious", Done, 0);
      end
      if (stall) begin
        check("hold_valid", Tx_Valid, 1);
        check("hold_data", Tx_Data, stall_data);
      end
      stall      = Tx_Valid && !Tx_Ready;
      stall_data = Tx_Data;
      if (Tx_Valid && Tx_Ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_byte: got %0h expected none", Tx_Data);
        end else begin
          me = exp_q.pop_front();
          check("frame_byte", Tx_Data, me.data);
          if (me.last) begin
            pend    = 1'b1;
            pend_fs = me.fs;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    Reset_n  = 1'b0;
    Start    = 1'b0;
    Count0   = '0;
    Count1   = '0;
    Tx_Ready = 1'b1;
    tick();
    tick();
    check("rst_valid", Tx_Valid, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_overrun", Overrun, 0);
    check("rst_data", Tx_Data, 0);
    check("rst_frames", Frames_Sent, 0);
    Reset_n = 1'b1;
    tick();

    // Basic frame
    rdy_mode = 0;
    start_frame(64'h5, 64'h2, 8'hA2);
    wait_idle();

    // Backpressure
    rdy_mode = 1;
    start_frame(64'h0123456789ABCDEF, 64'h0, 8'hA5);
    wait_idle();
    rdy_mode = 0;
    tick();

    // Snapshot isolation
    start_frame(64'h1000, 64'hFEDCBA9876543210, 8'hB5);
    inc_c0 = 1'b1;
    wait_idle();
    inc_c0 = 1'b0;

    // Overrun mid-frame and on the CHK edge, then Start in the Done cycle
    start_frame(64'h5, 64'h2, 8'hA2);
    repeat (5) tick();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("overrun_mid", Overrun, 1);
    tick();
    check("overrun_mid_clear", Overrun, 0);
    repeat (10) tick();
    Start = 1'b1;
    tick();
    check("overrun_chk", Overrun, 1);
    check("chk_edge_idle", Busy, 0);
    push_frame(64'h5, 64'h2, 8'hA2);
    tick();
    Start = 1'b0;
    check("overrun_chk_clear", Overrun, 0);
    check("done_cycle_start_busy", Busy, 1);
    check("done_cycle_start_valid", Tx_Valid, 1);
    wait_idle();

    // Reset while stalled in C1
    start_frame(64'hFFFFFFFFFFFFFFFF, 64'h8000000000000001, 8'h24);
    repeat (11) tick();
    rdy_mode = 2;
    tick();
    tick();
    check("pre_rst_busy", Busy, 1);
    Reset_n = 1'b0;
    #1;
    check("async_rst_valid", Tx_Valid, 0);
    check("async_rst_busy", Busy, 0);
    check("async_rst_frames", Frames_Sent, 0);
    exp_q.delete();
    model_fs = 16'h0000;
    tick();
    tick();
    Reset_n  = 1'b1;
    rdy_mode = 0;
    tick();
    start_frame(64'hFFFFFFFFFFFFFFFF, 64'h8000000000000001, 8'h24);
    wait_idle();

    // Frames_Sent wrap
    force dut.r_frames_sent = 16'hFFFE;
    tick();
    release dut.r_frames_sent;
    model_fs = 16'hFFFE;
    tick();
    start_frame(64'h0, 64'h0, 8'hA5);
    wait_idle();
    start_frame(64'h0, 64'h0, 8'hA5);
    wait_idle();
    check("wrap_zero", Frames_Sent, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
